// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory access arbiter: state encodings,
// default bus widths and a one-hot grant helper.
package mem_ctrl_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 16;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    function automatic logic [3:0] oneHot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mem_access_arbiter_if.sv
// Core-side and memory-side signals of the four-core memory access arbiter.
interface mem_access_arbiter_if #(
    parameter int unsigned ADDR_W = mem_ctrl_pkg::ADDR_W_DEF,
    parameter int unsigned DATA_W = mem_ctrl_pkg::DATA_W_DEF
);
    logic [3:0]        req;
    logic [3:0]        we;
    logic [ADDR_W-1:0] addr1, addr2, addr3, addr4;
    logic [DATA_W-1:0] wdata1, wdata2, wdata3, wdata4;
    logic [3:0]        gnt;
    logic [3:0]        done;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] memAddr;
    logic              memWR;
    logic              MemREAD;
    logic [DATA_W-1:0] datatoMem;
    logic [DATA_W-1:0] datafromMem;

    modport slave (
        input  req, we, addr1, addr2, addr3, addr4,
        input  wdata1, wdata2, wdata3, wdata4, datafromMem,
        output gnt, done, rdata, memAddr, memWR, MemREAD, datatoMem
    );

    modport master (
        output req, we, addr1, addr2, addr3, addr4,
        output wdata1, wdata2, wdata3, wdata4, datafromMem,
        input  gnt, done, rdata, memAddr, memWR, MemREAD, datatoMem
    );
endinterface

// File: rtl/rr_pick4.sv
// Round-robin picker: first asserted request searching ptr, ptr+1, ... mod 4.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       valid,
    output logic [1:0] idx
);
    // Walk from the farthest candidate inward so the nearest one wins.
    always_comb begin
        valid = |req;
        idx   = ptr;
        for (int k = 3; k >= 0; k--) begin
            if (req[2'(ptr + 2'(k))]) begin
                idx = 2'(ptr + 2'(k));
            end
        end
    end
endmodule

// File: rtl/mem_access_arbiter.sv
// Four-core round-robin arbiter for a single data memory port; one
// transaction at a time, loads wait MEM_LAT cycles for read data.
module mem_access_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic               clk,
    input  logic               reset,
    mem_access_arbiter_if.slave bus
);
    localparam logic [2:0] CNT_LAST = 3'(MEM_LAT - 1);

    logic [1:0]        stateQ, stateNext;
    logic [1:0]        rrQ, rrNext;
    logic [2:0]        cntQ, cntNext;
    logic [1:0]        winIdxQ, winIdxNext;
    logic              winWeQ, winWeNext;
    logic [3:0]        gntQ, gntNext;
    logic [3:0]        doneQ, doneNext;
    logic [DATA_W-1:0] rdataQ, rdataNext;
    logic [ADDR_W-1:0] memAddrQ, memAddrNext;
    logic              memWRQ, memWRNext;
    logic              memReadQ, memReadNext;
    logic [DATA_W-1:0] datatoMemQ, datatoMemNext;

    logic              pickValid;
    logic [1:0]        pickIdx;
    logic [ADDR_W-1:0] selAddr;
    logic [DATA_W-1:0] selData;

    rr_pick4 u_pick (
        .req   (bus.req),
        .ptr   (rrQ),
        .valid (pickValid),
        .idx   (pickIdx)
    );

    always_comb begin
        case (pickIdx)
            2'd0:    begin selAddr = bus.addr1; selData = bus.wdata1; end
            2'd1:    begin selAddr = bus.addr2; selData = bus.wdata2; end
            2'd2:    begin selAddr = bus.addr3; selData = bus.wdata3; end
            default: begin selAddr = bus.addr4; selData = bus.wdata4; end
        endcase
    end

    // Next state plus next value of every registered output.
    always_comb begin
        stateNext     = stateQ;
        rrNext        = rrQ;
        cntNext       = cntQ;
        winIdxNext    = winIdxQ;
        winWeNext     = winWeQ;
        gntNext       = gntQ;
        doneNext      = 4'b0000;
        rdataNext     = rdataQ;
        memAddrNext   = '0;
        memWRNext     = 1'b0;
        memReadNext   = 1'b0;
        datatoMemNext = '0;

        case (stateQ)
            IDLE: begin
                gntNext = 4'b0000;
                if (pickValid) begin
                    winIdxNext    = pickIdx;
                    winWeNext     = bus.we[pickIdx];
                    gntNext       = oneHot4(pickIdx);
                    memAddrNext   = selAddr;
                    memWRNext     = bus.we[pickIdx];
                    memReadNext   = ~bus.we[pickIdx];
                    datatoMemNext = bus.we[pickIdx] ? selData : '0;
                    stateNext     = ACCESS;
                end
            end
            ACCESS: begin
                cntNext = 3'd0;
                if (winWeQ) begin
                    doneNext  = oneHot4(winIdxQ);
                    stateNext = DONE;
                end else begin
                    stateNext = WAIT;
                end
            end
            WAIT: begin
                if (cntQ == CNT_LAST) begin
                    rdataNext = bus.datafromMem;
                    doneNext  = oneHot4(winIdxQ);
                    cntNext   = 3'd0;
                    stateNext = DONE;
                end else begin
                    cntNext = cntQ + 3'd1;
                end
            end
            default: begin
                rrNext    = winIdxQ + 2'd1;
                gntNext   = 4'b0000;
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ     <= IDLE;
            rrQ        <= 2'd0;
            cntQ       <= 3'd0;
            winIdxQ    <= 2'd0;
            winWeQ     <= 1'b0;
            gntQ       <= 4'b0000;
            doneQ      <= 4'b0000;
            rdataQ     <= '0;
            memAddrQ   <= '0;
            memWRQ     <= 1'b0;
            memReadQ   <= 1'b0;
            datatoMemQ <= '0;
        end else begin
            stateQ     <= stateNext;
            rrQ        <= rrNext;
            cntQ       <= cntNext;
            winIdxQ    <= winIdxNext;
            winWeQ     <= winWeNext;
            gntQ       <= gntNext;
            doneQ      <= doneNext;
            rdataQ     <= rdataNext;
            memAddrQ   <= memAddrNext;
            memWRQ     <= memWRNext;
            memReadQ   <= memReadNext;
            datatoMemQ <= datatoMemNext;
        end
    end

    assign bus.gnt       = gntQ;
    assign bus.done      = doneQ;
    assign bus.rdata     = rdataQ;
    assign bus.memAddr   = memAddrQ;
    assign bus.memWR     = memWRQ;
    assign bus.MemREAD   = memReadQ;
    assign bus.datatoMem = datatoMemQ;
endmodule
